uart_tx_param: RTL and testbench
================================

Name: uart_tx_param

Overview:
- Parametrised next-generation UART transmitter for the system's UART path.
- Generalises the fixed 8-bit, one-clock-per-bit transmitter:
  - configurable data width
  - runtime baud prescale (clocks per bit)
  - optional second stop bit
  - explicit accept strobe
  - gap-free back-to-back frames
- Consumes parallel words from the system controller or FIFO side and drives the serial TX line.

Parameters:
- DATA_WIDTH, 8, number of data bits per frame (5..9).
- PRESCALE_WIDTH, 6, width of the clocks-per-bit input.

Ports:
- CLK  in  1  transmitter clock; all logic on rising edge.
- RST  in  1  synchronous active-low reset.
- Data_Valid  in  1  request to send P_DATA; sampled only when the block can accept.
- P_DATA  in  DATA_WIDTH  word to transmit, sent LSB first.
- PAR_EN  in  1  1 = append a parity bit.
- PAR_TYP  in  1  0 = even, 1 = odd parity.
- STOP2  in  1  1 = two stop bits, 0 = one.
- Prescale  in  PRESCALE_WIDTH  clocks per serial bit; 0 is treated as 1.
- TX_OUT  out  1  serial line; idle high.
- busy  out  1  high while a frame is on the line.
- Data_Accept  out  1  one-cycle pulse on the edge that captures a word.

Behaviour:
- Clock and reset: one clock, CLK. Reset RST is synchronous, active-low; it takes effect on a rising CLK edge while low.
- Reset values: TX_OUT=1, busy=0, Data_Accept=0, state=IDLE, all counters 0.
- Reset mid-frame: the frame aborts and TX_OUT=1 after that edge. No partial stop bit is sent.
- States: IDLE, START, DATA, PARITY, STOP.
- Accept condition: Data_Valid=1 and either
  - state=IDLE, or
  - last clock of the last stop bit.
- On an accepting edge:
  - latch P_DATA, PAR_EN, PAR_TYP, STOP2 and the effective Prescale into frame registers.
  - Data_Accept=1 for that one cycle.
  - next state = START.
- Inputs are ignored at all other times. Input changes mid-frame never alter the frame in flight.
- All outputs are registered. After the accepting edge: TX_OUT=0 (start bit), busy=1.
- Bit timing: each bit is held for exactly P clocks, where P = latched effective Prescale. A per-bit counter runs 0..P-1.
- Bit sequence:
  - START: 1 bit.
  - DATA: DATA_WIDTH bits, bit index 0 first.
  - PARITY: only if PAR_EN; even = XOR of data, odd = inverted XOR.
  - STOP: 1 or 2 bits at 1.
- Frame length = (2 + DATA_WIDTH + PAR_EN + STOP2) × P clocks.
- End of frame:
  - No accept: IDLE next cycle, TX_OUT=1, busy=0.
  - Accept on the last stop clock: go directly to START. busy stays 1 and there is no idle gap.
- Parity computation uses the latched data only.
- Prescale=0 behaves identically to Prescale=1.
- Data_Valid held high continuously: frames stream back-to-back, one accept per frame.

Test Plan:
1. Reset, then IDLE for 5 cycles -> TX_OUT=1, busy=0, Data_Accept=0.
2. DATA_WIDTH=8, Prescale=1, send 0x0A, PAR_EN=0 -> Data_Accept pulse, then TX_OUT = 0,0,1,0,1,0,0,0,0,1 (10 clocks); busy high exactly 10 clocks.
3. Send 0x0A with even parity, then with odd parity (Prescale=1) -> parity bit 0 and 1 respectively; frame 11 clocks each.
4. Back-to-back, Data_Valid asserted on the last stop clock: 0x0F odd parity then 0x0E even parity -> parity bits 1 and 1. Second start bit immediately follows the first stop bit; busy never drops between frames; two Data_Accept pulses 11 clocks apart.
5. Prescale=4, STOP2=1, 0x0A, no parity -> every bit lasts 4 clocks; frame 44 clocks; final 8 clocks high.
6. Mid-frame disturbance and reset:
   - During a 0x0A frame, set P_DATA=0xFF and pulse Data_Valid -> ignored, transmitted bits unchanged, no Data_Accept.
   - RST=0 during DATA -> next edge TX_OUT=1, busy=0; after release the next frame starts cleanly.

Source files
------------

// File: rtl/uart_tx_param.sv
// uart_tx_param: parametrised UART transmitter.
//
// Takes a parallel word and sends it on TX_OUT. A frame is one start bit
// (0), DATA_WIDTH data bits LSB first, an optional parity bit and one or two
// stop bits (1). Every bit lasts Prescale clocks, and a Prescale of 0 counts
// as 1. A new word can be accepted on the last clock of the last stop bit,
// so frames can follow each other with no idle gap.
//
// Ports:
//   CLK          transmitter clock, rising edge
//   RST          synchronous active-low reset
//   Data_Valid   request to send P_DATA
//   P_DATA       word to transmit
//   PAR_EN       1 = append a parity bit
//   PAR_TYP      0 = even parity, 1 = odd parity
//   STOP2        1 = two stop bits
//   Prescale     clocks per serial bit
//   TX_OUT       serial line, idle high
//   busy         high while a frame is on the line
//   Data_Accept  one-cycle pulse after the edge that captured a word
//
// state  | meaning
// IDLE   | line idle high, waiting for Data_Valid
// START  | driving the start bit (0)
// DATA   | driving data bit idx
// PARITY | driving the parity bit
// STOP   | driving stop bit idx (0 or 1)
module uart_tx_param #(
  parameter int DATA_WIDTH     = 8,
  parameter int PRESCALE_WIDTH = 6
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      Data_Valid,
  input  logic [DATA_WIDTH-1:0]     P_DATA,
  input  logic                      PAR_EN,
  input  logic                      PAR_TYP,
  input  logic                      STOP2,
  input  logic [PRESCALE_WIDTH-1:0] Prescale,
  output logic                      TX_OUT,
  output logic                      busy,
  output logic                      Data_Accept
);

  localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t                    state, state_n;
  logic [PRESCALE_WIDTH-1:0] cnt, cnt_n;
  logic [PRESCALE_WIDTH-1:0] presc_q, presc_n, presc_eff;
  logic [IDX_W-1:0]          idx, idx_n;
  logic [DATA_WIDTH-1:0]     data_q, data_n;
  logic                      par_en_q, par_en_n;
  logic                      par_typ_q, par_typ_n;
  logic                      stop2_q, stop2_n;
  logic                      bit_end, last_stop, accept;
  logic                      tx_n, busy_n;

  assign presc_eff = (Prescale == '0) ? PRESCALE_WIDTH'(1) : Prescale;
  assign bit_end   = (cnt == presc_q - PRESCALE_WIDTH'(1));
  // idx counts stop bits too: the last one is index 1 with STOP2, else 0.
  assign last_stop = (state == STOP) && bit_end && (idx == IDX_W'(stop2_q));
  assign accept    = Data_Valid && ((state == IDLE) || last_stop);

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    idx_n     = idx;
    data_n    = data_q;
    presc_n   = presc_q;
    par_en_n  = par_en_q;
    par_typ_n = par_typ_q;
    stop2_n   = stop2_q;

    if (accept) begin
      data_n    = P_DATA;
      presc_n   = presc_eff;
      par_en_n  = PAR_EN;
      par_typ_n = PAR_TYP;
      stop2_n   = STOP2;
      state_n   = START;
      cnt_n     = '0;
      idx_n     = '0;
    end else if (state != IDLE) begin
      if (!bit_end) begin
        cnt_n = cnt + PRESCALE_WIDTH'(1);
      end else begin
        cnt_n = '0;
        case (state)
          START: begin
            state_n = DATA;
            idx_n   = '0;
          end
          DATA: begin
            if (idx == IDX_W'(DATA_WIDTH - 1)) begin
              idx_n   = '0;
              state_n = par_en_q ? PARITY : STOP;
            end else begin
              idx_n = idx + IDX_W'(1);
            end
          end
          PARITY: begin
            state_n = STOP;
            idx_n   = '0;
          end
          STOP: begin
            if (last_stop) begin
              state_n = IDLE;
              idx_n   = '0;
            end else begin
              idx_n = idx + IDX_W'(1);
            end
          end
          default: begin
            state_n = IDLE;
            idx_n   = '0;
          end
        endcase
      end
    end

    // Outputs are registered, so the line value is derived from the next
    // state and the next frame registers.
    case (state_n)
      START:   tx_n = 1'b0;
      DATA:    tx_n = data_n[idx_n];
      PARITY:  tx_n = (^data_n) ^ par_typ_n;
      default: tx_n = 1'b1;
    endcase
    busy_n = (state_n != IDLE);
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state       <= IDLE;
      cnt         <= '0;
      idx         <= '0;
      data_q      <= '0;
      presc_q     <= '0;
      par_en_q    <= 1'b0;
      par_typ_q   <= 1'b0;
      stop2_q     <= 1'b0;
      TX_OUT      <= 1'b1;
      busy        <= 1'b0;
      Data_Accept <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      idx         <= idx_n;
      data_q      <= data_n;
      presc_q     <= presc_n;
      par_en_q    <= par_en_n;
      par_typ_q   <= par_typ_n;
      stop2_q     <= stop2_n;
      TX_OUT      <= tx_n;
      busy        <= busy_n;
      Data_Accept <= accept;
    end
  end

endmodule

// File: tb/tb_uart_tx_param.sv
module tb_uart_tx_param;

  logic       CLK;
  logic       RST;
  logic       Data_Valid;
  logic [7:0] P_DATA;
  logic       PAR_EN;
  logic       PAR_TYP;
  logic       STOP2;
  logic [5:0] Prescale;
  logic       TX_OUT;
  logic       busy;
  logic       Data_Accept;

  int n_vec = 0;
  int n_err = 0;
  bit model_chk = 0;
  bit mq[$];

  uart_tx_param #(.DATA_WIDTH(8), .PRESCALE_WIDTH(6)) dut (
    .CLK(CLK), .RST(RST), .Data_Valid(Data_Valid), .P_DATA(P_DATA),
    .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .STOP2(STOP2), .Prescale(Prescale),
    .TX_OUT(TX_OUT), .busy(busy), .Data_Accept(Data_Accept)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // bits: bit c is the line value of serial bit c in transmit order.
  typedef struct {
    logic [7:0]  data;
    logic        par_en;
    logic        par_typ;
    logic        stop2;
    logic [5:0]  presc;
    logic [15:0] bits;
    int          len;
  } vec_t;

  vec_t tbl[7];

  task automatic chk(input string name, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, got, exp);
    end
  endtask

  // Behavioural reference: a queue holding the line value for each future
  // clock. A word is accepted when the queue is empty (idle) or holds only
  // the clock currently on the line (last stop clock).
  initial begin
    bit acc;
    int p;
    forever begin
      @(posedge CLK);
      acc = 1'b0;
      if (!RST) begin
        mq.delete();
      end else begin
        acc = Data_Valid && (mq.size() <= 1);
        if (mq.size() > 0) void'(mq.pop_front());
        if (acc) begin
          p = (Prescale == 0) ? 1 : int'(Prescale);
          repeat (p) mq.push_back(1'b0);
          for (int i = 0; i < 8; i++) repeat (p) mq.push_back(P_DATA[i]);
          if (PAR_EN) repeat (p) mq.push_back((^P_DATA) ^ PAR_TYP);
          repeat (p) mq.push_back(1'b1);
          if (STOP2) repeat (p) mq.push_back(1'b1);
        end
      end
      #1;
      if (model_chk) begin
        chk("model tx", int'(TX_OUT), (mq.size() > 0) ? int'(mq[0]) : 1);
        chk("model busy", int'(busy), (mq.size() > 0) ? 1 : 0);
        chk("model accept", int'(Data_Accept), int'(acc));
      end
    end
  end

  task automatic run_frame(input vec_t v, input string tag);
    int p;
    int busy_cnt;
    p = (v.presc == 0) ? 1 : int'(v.presc);
    @(negedge CLK);
    P_DATA = v.data; PAR_EN = v.par_en; PAR_TYP = v.par_typ;
    STOP2 = v.stop2; Prescale = v.presc; Data_Valid = 1'b1;
    @(posedge CLK); #1;
    chk({tag, " accept"}, int'(Data_Accept), 1);
    busy_cnt = 0;
    for (int c = 0; c < v.len; c++) begin
      chk({tag, " tx"}, int'(TX_OUT), int'(v.bits[c / p]));
      if (busy) busy_cnt++;
      if (c > 0) chk({tag, " no accept"}, int'(Data_Accept), 0);
      @(negedge CLK);
      // Scramble every input mid-frame and pulse Data_Valid once with 0xFF.
      P_DATA = (c == 3) ? 8'hFF : 8'($urandom);
      PAR_EN = 1'($urandom); PAR_TYP = 1'($urandom);
      STOP2 = 1'($urandom); Prescale = 6'($urandom);
      Data_Valid = (c == 3);
      @(posedge CLK); #1;
    end
    chk({tag, " busy len"}, busy_cnt, v.len);
    chk({tag, " idle tx"}, int'(TX_OUT), 1);
    chk({tag, " idle busy"}, int'(busy), 0);
    chk({tag, " idle accept"}, int'(Data_Accept), 0);
  endtask

  initial begin
    logic [31:0] b2b;
    int acc_at[$];

    tbl[0] = '{8'h0A, 1'b0, 1'b0, 1'b0, 6'd1, 16'h0214, 10};
    tbl[1] = '{8'h0A, 1'b1, 1'b0, 1'b0, 6'd1, 16'h0414, 11};
    tbl[2] = '{8'h0A, 1'b1, 1'b1, 1'b0, 6'd1, 16'h0614, 11};
    tbl[3] = '{8'h0A, 1'b0, 1'b0, 1'b1, 6'd4, 16'h0614, 44};
    tbl[4] = '{8'h0A, 1'b0, 1'b0, 1'b0, 6'd0, 16'h0214, 10};
    tbl[5] = '{8'hF0, 1'b1, 1'b1, 1'b0, 6'd2, 16'h07E0, 22};
    tbl[6] = '{8'h55, 1'b1, 1'b0, 1'b1, 6'd3, 16'h0CAA, 36};

    RST = 1'b0; Data_Valid = 1'b0; P_DATA = '0; PAR_EN = 1'b0;
    PAR_TYP = 1'b0; STOP2 = 1'b0; Prescale = 6'd1;

    // Reset and idle
    repeat (3) @(posedge CLK);
    #1;
    chk("reset tx", int'(TX_OUT), 1);
    chk("reset busy", int'(busy), 0);
    chk("reset accept", int'(Data_Accept), 0);
    @(negedge CLK); RST = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge CLK); #1;
      chk("idle tx", int'(TX_OUT), 1);
      chk("idle busy", int'(busy), 0);
      chk("idle accept", int'(Data_Accept), 0);
    end

    for (int i = 0; i < 7; i++) run_frame(tbl[i], $sformatf("vec%0d", i));

    // Back-to-back: 0x0F odd then 0x0E even, second accepted on last stop clock
    b2b = 32'h0030_E61E;
    @(negedge CLK);
    P_DATA = 8'h0F; PAR_EN = 1'b1; PAR_TYP = 1'b1; STOP2 = 1'b0;
    Prescale = 6'd1; Data_Valid = 1'b1;
    @(posedge CLK); #1;
    for (int c = 0; c < 22; c++) begin
      chk("b2b tx", int'(TX_OUT), int'(b2b[c]));
      chk("b2b busy", int'(busy), 1);
      if (Data_Accept) acc_at.push_back(c);
      @(negedge CLK);
      if (c == 10) begin
        P_DATA = 8'h0E; PAR_TYP = 1'b0; Data_Valid = 1'b1;
      end else begin
        Data_Valid = 1'b0;
      end
      @(posedge CLK); #1;
    end
    chk("b2b accept count", acc_at.size(), 2);
    if (acc_at.size() == 2) chk("b2b accept gap", acc_at[1] - acc_at[0], 11);
    chk("b2b end busy", int'(busy), 0);
    chk("b2b end tx", int'(TX_OUT), 1);

    // Reset during DATA
    @(negedge CLK);
    P_DATA = 8'h0A; PAR_EN = 1'b0; STOP2 = 1'b0; Prescale = 6'd2;
    Data_Valid = 1'b1;
    @(posedge CLK);
    @(negedge CLK); Data_Valid = 1'b0;
    repeat (4) @(posedge CLK);
    #1;
    chk("pre-reset busy", int'(busy), 1);
    @(negedge CLK); RST = 1'b0;
    @(posedge CLK); #1;
    chk("midreset tx", int'(TX_OUT), 1);
    chk("midreset busy", int'(busy), 0);
    chk("midreset accept", int'(Data_Accept), 0);
    @(negedge CLK); RST = 1'b1;
    @(posedge CLK); #1;
    chk("post-reset tx", int'(TX_OUT), 1);
    chk("post-reset busy", int'(busy), 0);
    run_frame(tbl[1], "post_rst");

    // Randomised traffic against the reference model
    @(negedge CLK);
    model_chk = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      @(negedge CLK);
      Data_Valid = ($urandom_range(0, 2) == 0);
      P_DATA = 8'($urandom);
      PAR_EN = 1'($urandom); PAR_TYP = 1'($urandom); STOP2 = 1'($urandom);
      Prescale = 6'($urandom_range(0, 4));
      RST = ($urandom_range(0, 799) != 0);
    end
    @(negedge CLK);
    RST = 1'b1; Data_Valid = 1'b0;
    @(posedge CLK); #2;
    model_chk = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
